// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage RV32 core: stall/flush per inter-stage register,
// fetch redirect arbitration, and precise trap entry that drains the pipe before vectoring.
package pipeline_hazard_controller_pkg;
    typedef struct packed {
        logic stall;
        logic flush;
    } stageControl_t;
endpackage

module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR_W    = 5,
    parameter int unsigned TRAP_DRAIN    = 1,
    parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
    parameter logic [31:0] CAUSE_EXT_IRQ = 32'h8000000B
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exLoad,
    input  logic                  exValid,
    input  logic                  branchTaken,
    input  logic [31:0]           branchTarget,
    input  logic                  memValid,
    input  logic                  memIllegal,
    input  logic [31:0]           memPC,
    input  logic                  interrupt,
    input  logic                  interruptEnable,
    input  logic [31:0]           mtvec,
    input  logic                  imemBusy,
    input  logic                  dmemBusy,
    output stageControl_t         fetchDecodeControl,
    output stageControl_t         decodeExecuteControl,
    output stageControl_t         executeMemoryControl,
    output stageControl_t         memoryWritebackControl,
    output logic                  redirectValid,
    output logic [31:0]           redirectPC,
    output logic                  trapTake,
    output logic [31:0]           trapCause,
    output logic [31:0]           trapPC
);
    localparam int unsigned CNT_W = $clog2(TRAP_DRAIN + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           state;
    state_t           nextState;
    logic             pendingFlush;
    logic             nextPendingFlush;
    logic [CNT_W-1:0] drainCount;
    logic [CNT_W-1:0] nextDrainCount;
    logic             trapCond;
    logic             loadUse;

    // Traps are only taken on a real instruction whose memory access has completed.
    assign trapCond = memValid & ~dmemBusy & (memIllegal | (interrupt & interruptEnable));
    assign loadUse  = idValid & exValid & exLoad & (exRd != '0) &
                      ((idUsesRs1 & (idRs1 == exRd)) | (idUsesRs2 & (idRs2 == exRd)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            pendingFlush <= 1'b0;
            drainCount   <= '0;
        end else begin
            state        <= nextState;
            pendingFlush <= nextPendingFlush;
            drainCount   <= nextDrainCount;
        end
    end

    always_comb begin
        nextState        = state;
        nextPendingFlush = pendingFlush;
        nextDrainCount   = drainCount;
        case (state)
            RUN: begin
                if (trapCond) begin
                    nextState        = DRAIN;
                    nextPendingFlush = 1'b0;
                    nextDrainCount   = CNT_W'(TRAP_DRAIN - 1);
                end else if (dmemBusy) begin
                    if (branchTaken) nextPendingFlush = 1'b1;
                end else if (branchTaken | pendingFlush) begin
                    nextPendingFlush = 1'b0;
                end
            end
            DRAIN: begin
                if (drainCount == '0) nextState = REDIRECT;
                else                  nextDrainCount = drainCount - CNT_W'(1);
            end
            REDIRECT: begin
                if (!imemBusy) nextState = RUN;
            end
            default: nextState = RUN;
        endcase
    end

    always_comb begin
        fetchDecodeControl     = '0;
        decodeExecuteControl   = '0;
        executeMemoryControl   = '0;
        memoryWritebackControl = '0;
        redirectValid          = 1'b0;
        redirectPC             = 32'd0;
        trapTake               = 1'b0;
        trapCause              = 32'd0;
        trapPC                 = 32'd0;
        if (reset) begin
            fetchDecodeControl.flush     = 1'b1;
            decodeExecuteControl.flush   = 1'b1;
            executeMemoryControl.flush   = 1'b1;
            memoryWritebackControl.flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (trapCond) begin
                        trapTake                     = 1'b1;
                        trapPC                       = memPC;
                        trapCause                    = memIllegal ? CAUSE_ILLEGAL : CAUSE_EXT_IRQ;
                        fetchDecodeControl.flush     = 1'b1;
                        decodeExecuteControl.flush   = 1'b1;
                        executeMemoryControl.flush   = 1'b1;
                        memoryWritebackControl.flush = 1'b1;
                    end else if (dmemBusy) begin
                        fetchDecodeControl.stall     = 1'b1;
                        decodeExecuteControl.stall   = 1'b1;
                        executeMemoryControl.stall   = 1'b1;
                        memoryWritebackControl.stall = 1'b1;
                        // Fetch takes the redirect now; the wrong-path flush is deferred.
                        if (branchTaken) begin
                            redirectValid = 1'b1;
                            redirectPC    = branchTarget;
                        end
                    end else if (branchTaken | pendingFlush) begin
                        fetchDecodeControl.flush   = 1'b1;
                        decodeExecuteControl.flush = 1'b1;
                        redirectValid              = branchTaken;
                        redirectPC                 = branchTarget;
                    end else if (loadUse) begin
                        fetchDecodeControl.stall   = 1'b1;
                        decodeExecuteControl.flush = 1'b1;
                    end else if (imemBusy) begin
                        fetchDecodeControl.flush = 1'b1;
                    end
                end
                DRAIN: begin
                    fetchDecodeControl.flush   = 1'b1;
                    decodeExecuteControl.flush = 1'b1;
                    executeMemoryControl.flush = 1'b1;
                end
                REDIRECT: begin
                    redirectValid            = 1'b1;
                    redirectPC               = mtvec & 32'hFFFF_FFFC;
                    fetchDecodeControl.flush = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central sequencer for the 5-stage RV32 pipeline. Generates stall/flush controls for every inter-stage register and arbitrates between fetch redirect sources: branch/jump from Execute, trap entry to mtvec.
Detects load-use hazards, data-memory wait states and precise traps at the Memory stage. Runs a small FSM so that trap entry drains the pipeline before redirecting fetch. Branch redirects that arrive during a stall are latched until the stall releases.

Parameters:
REG_ADDR_W, 5, register-index width
TRAP_DRAIN, 1, cycles spent in DRAIN before redirect (>=1)
CAUSE_ILLEGAL, 32'd2, mcause value for illegal instruction / misaligned target
CAUSE_EXT_IRQ, 32'h8000000B, mcause value for machine external interrupt

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
idRs1  in  REG_ADDR_W  decode source register 1
idRs2  in  REG_ADDR_W  decode source register 2
idUsesRs1  in  1  decode instruction reads rs1
idUsesRs2  in  1  decode instruction reads rs2
idValid  in  1  decode slot holds a valid instruction
exRd  in  REG_ADDR_W  execute destination register
exLoad  in  1  execute instruction is a load
exValid  in  1  execute slot valid
branchTaken  in  1  gated branch/jump taken from Execute
branchTarget  in  32  branch/jump target from Execute
memValid  in  1  memory-stage instruction valid
memIllegal  in  1  memory-stage instruction flagged illegal
memPC  in  32  memory-stage program counter
interrupt  in  1  external interrupt request (level)
interruptEnable  in  1  mstatus.MIE
mtvec  in  32  trap vector base
imemBusy  in  1  instruction memory not returning data this cycle
dmemBusy  in  1  data memory not ready this cycle
fetchDecodeControl  out  control  stall/flush for the F/D register
decodeExecuteControl  out  control  stall/flush for the D/E register
executeMemoryControl  out  control  stall/flush for the E/M register
memoryWritebackControl  out  control  stall/flush for the M/W register
redirectValid  out  1  fetch must load redirectPC
redirectPC  out  32  new fetch address
trapTake  out  1  one-cycle pulse, CSR file writes mepc/mcause
trapCause  out  32  mcause value, valid with trapTake
trapPC  out  32  mepc value (memPC), valid with trapTake

Behaviour:
- FSM states: RUN, DRAIN, REDIRECT. Also a pendingFlush flag and a drain counter of ceil(log2(TRAP_DRAIN+1)) bits.
- Reset: state=RUN, pendingFlush=0, counter=0. While reset is high, all four flush=1, all stall=0, redirectValid=0, trapTake=0, redirectPC=0, trapCause=0, trapPC=0.
- Outputs are combinational from state and inputs. Zero-latency control.
- Default in RUN: all stall=0, all flush=0, redirectValid=0, trapTake=0.
- RUN priority, highest first:
  1. Trap: memValid & !dmemBusy & (memIllegal | (interrupt & interruptEnable)).
     - trapTake=1; trapPC=memPC.
     - trapCause=CAUSE_ILLEGAL if memIllegal, else CAUSE_EXT_IRQ (illegal wins).
     - Flush F/D, D/E, E/M and M/W, so the trapping instruction does not commit. Clear pendingFlush.
     - Next state DRAIN, counter=TRAP_DRAIN-1.
  2. dmemBusy: all four stall=1.
     - If branchTaken: redirectValid=1, redirectPC=branchTarget, set pendingFlush. Fetch accepts the redirect while stalled.
  3. branchTaken | pendingFlush: F/D flush=1, D/E flush=1, clear pendingFlush.
     - redirectValid=branchTaken, redirectPC=branchTarget.
  4. Load-use: idValid & exValid & exLoad & exRd!=0 & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
     - F/D stall=1, D/E flush=1 (bubble).
  5. imemBusy: F/D flush=1 (bubble into decode).
- DRAIN: F/D, D/E and E/M flush=1; M/W free; branchTaken ignored.
  - Counter decrements each cycle. At 0, go to REDIRECT.
- REDIRECT: redirectValid=1, redirectPC={mtvec[31:2],2'b00}, F/D flush=1.
  - Held until imemBusy=0, then RUN.
- Interrupt sampled only in RUN with memValid. No trap is taken on a bubble.
- Simultaneous trap and branchTaken: trap wins, branch dropped (younger instruction).
- Simultaneous dmemBusy and trap condition: stall. The trap is taken on the first non-busy cycle.
- Load-use while dmemBusy: stall-all only, no D/E flush.
- Reset mid-DRAIN/REDIRECT: returns to RUN next cycle, no redirect issued.

Test Plan:
- Load-use: exLoad=1, exRd=5, idRs2=5, idUsesRs2=1, valid both -> F/D stall=1, D/E flush=1 for exactly 1 cycle. With exRd=0 -> no stall.
- Branch: branchTaken=1, target 0x100 -> redirectValid=1, redirectPC=0x100, F/D and D/E flush=1 same cycle.
- Branch under stall: dmemBusy=1 with branchTaken=1 (target 0x200) for one cycle, busy for 3 more cycles -> redirect in first cycle, all stalls held. First cycle after busy drops: F/D and D/E flush=1, redirectValid=0.
- Illegal trap: memIllegal=1, memPC=0x40, mtvec=0x80 -> trapTake pulse, cause 2, trapPC 0x40, all flush. One DRAIN cycle, then redirectValid=1 to 0x80. With imemBusy=1 for 2 cycles, redirect held 3 cycles, then RUN.
- Interrupt: interrupt=1, interruptEnable=1, memValid=1, memIllegal=1 -> cause 2. Repeat with memIllegal=0 -> cause 0x8000000B. With interruptEnable=0 or memValid=0 -> no trap.
- Reset asserted during REDIRECT -> all flush=1, redirectValid=0. After release: RUN, and no redirect until a new event.
